// File: rtl/tile_dispatch.sv
// Tile dispatcher: bounds a triangle in screen tiles and issues one raster job per covered tile.

`ifndef FX_FRAC_BITS
`define FX_FRAC_BITS 4
`endif
`ifndef COLOR_BITS
`define COLOR_BITS 8
`endif
`ifndef TILE_COLUMNS_BITS
`define TILE_COLUMNS_BITS 4
`endif
`ifndef TILE_ROWS_BITS
`define TILE_ROWS_BITS 4
`endif
`ifndef COORD_BITS
`define COORD_BITS 16
`endif

package tile_dispatch_pkg;
    localparam int unsigned COORD_W = `COORD_BITS;
    localparam int unsigned FX_W    = `FX_FRAC_BITS;
    localparam int unsigned COLOR_W = `COLOR_BITS;
    localparam int unsigned COL_W   = `TILE_COLUMNS_BITS;
    localparam int unsigned ROW_W   = `TILE_ROWS_BITS;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } coord_3d_t;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [COL_W-1:0]   tile_x;
        logic [ROW_W-1:0]   tile_y;
    } metadata_t;
endpackage

module tile_dispatch
    import tile_dispatch_pkg::*;
#(
    parameter int unsigned TILE_W_LOG2 = 4,
    parameter int unsigned TILE_H_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld_in,
    output logic               rdy_in,
    input  coord_3d_t          v0,
    input  coord_3d_t          v1,
    input  coord_3d_t          v2,
    input  logic [COLOR_W-1:0] color,
    output logic               vld_out,
    input  logic               rdy_out,
    output coord_3d_t          tv0,
    output coord_3d_t          tv1,
    output coord_3d_t          tv2,
    output metadata_t          tmeta,
    output logic [15:0]        tile_cnt
);

    localparam logic signed [COORD_W-1:0] ZERO     = '0;
    localparam logic signed [COORD_W-1:0] LAST_COL = COORD_W'((1 << COL_W) - 1);
    localparam logic signed [COORD_W-1:0] LAST_ROW = COORD_W'((1 << ROW_W) - 1);

    typedef enum logic [1:0] {IDLE, BBOX, ISSUE} state_t;

    state_t             state_q;
    logic               vld_out_q;
    coord_3d_t          v0_q, v1_q, v2_q;
    logic [COLOR_W-1:0] color_q;
    logic [COL_W-1:0]   tile_x_q, min_tx_q, max_tx_q;
    logic [ROW_W-1:0]   tile_y_q, min_ty_q, max_ty_q;
    logic [15:0]        tile_cnt_q;

    function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a,
                                                        input logic signed [COORD_W-1:0] b,
                                                        input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a,
                                                        input logic signed [COORD_W-1:0] b,
                                                        input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [COL_W-1:0] clamp_col(input logic signed [COORD_W-1:0] t);
        if (t < ZERO)     return '0;
        if (t > LAST_COL) return '1;
        return t[COL_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] clamp_row(input logic signed [COORD_W-1:0] t);
        if (t < ZERO)     return '0;
        if (t > LAST_ROW) return '1;
        return t[ROW_W-1:0];
    endfunction

    // Bounding box of the latched triangle, in pixels and then in (raw and clamped) tiles
    logic signed [COORD_W-1:0] pmin_x, pmax_x, pmin_y, pmax_y;
    logic signed [COORD_W-1:0] tmin_x, tmax_x, tmin_y, tmax_y;
    logic                      cull;

    always_comb begin
        pmin_x = min3($signed(v0_q.x) >>> FX_W, $signed(v1_q.x) >>> FX_W, $signed(v2_q.x) >>> FX_W);
        pmax_x = max3($signed(v0_q.x) >>> FX_W, $signed(v1_q.x) >>> FX_W, $signed(v2_q.x) >>> FX_W);
        pmin_y = min3($signed(v0_q.y) >>> FX_W, $signed(v1_q.y) >>> FX_W, $signed(v2_q.y) >>> FX_W);
        pmax_y = max3($signed(v0_q.y) >>> FX_W, $signed(v1_q.y) >>> FX_W, $signed(v2_q.y) >>> FX_W);
        tmin_x = pmin_x >>> TILE_W_LOG2;
        tmax_x = pmax_x >>> TILE_W_LOG2;
        tmin_y = pmin_y >>> TILE_H_LOG2;
        tmax_y = pmax_y >>> TILE_H_LOG2;
        cull   = (pmax_x < ZERO) || (pmax_y < ZERO) || (tmin_x > LAST_COL) || (tmin_y > LAST_ROW);
    end

    // Row-major successor of the current tile and saturating job count
    logic               last_x, last_y;
    logic [COL_W-1:0]   tile_x_d;
    logic [ROW_W-1:0]   tile_y_d;
    logic [15:0]        tile_cnt_d;

    always_comb begin
        last_x     = (tile_x_q == max_tx_q);
        last_y     = (tile_y_q == max_ty_q);
        tile_x_d   = last_x ? min_tx_q : tile_x_q + COL_W'(1);
        tile_y_d   = last_x ? tile_y_q + ROW_W'(1) : tile_y_q;
        tile_cnt_d = (tile_cnt_q == 16'hFFFF) ? tile_cnt_q : tile_cnt_q + 16'd1;
    end

    // Dispatch FSM: accept, bound/cull for one cycle, then walk the tile range
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vld_out_q  <= 1'b0;
            v0_q       <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
            color_q    <= '0;
            tile_x_q   <= '0;
            tile_y_q   <= '0;
            min_tx_q   <= '0;
            max_tx_q   <= '0;
            min_ty_q   <= '0;
            max_ty_q   <= '0;
            tile_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vld_in && rdy_in) begin
                        v0_q    <= v0;
                        v1_q    <= v1;
                        v2_q    <= v2;
                        color_q <= color;
                        state_q <= BBOX;
                    end
                end
                BBOX: begin
                    if (cull) begin
                        state_q <= IDLE;
                    end else begin
                        min_tx_q  <= clamp_col(tmin_x);
                        max_tx_q  <= clamp_col(tmax_x);
                        min_ty_q  <= clamp_row(tmin_y);
                        max_ty_q  <= clamp_row(tmax_y);
                        tile_x_q  <= clamp_col(tmin_x);
                        tile_y_q  <= clamp_row(tmin_y);
                        vld_out_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (vld_out_q && rdy_out) begin
                        tile_cnt_q <= tile_cnt_d;
                        if (last_x && last_y) begin
                            vld_out_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            tile_x_q <= tile_x_d;
                            tile_y_q <= tile_y_d;
                        end
                    end
                end
                default: begin
                    vld_out_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign rdy_in   = rst_n && (state_q == IDLE);
    assign vld_out  = vld_out_q;
    assign tv0      = v0_q;
    assign tv1      = v1_q;
    assign tv2      = v2_q;
    assign tmeta    = '{color: color_q, tile_x: tile_x_q, tile_y: tile_y_q};
    assign tile_cnt = tile_cnt_q;

endmodule

// File: tb/tb_tile_dispatch.sv
// Bench for tile_dispatch: directed vector table, stall/reset sequences and random triangles vs a tile-list model.

module tb_tile_dispatch;
    import tile_dispatch_pkg::*;

    localparam int TW   = 4;
    localparam int TH   = 4;
    localparam int NCOL = 1 << COL_W;
    localparam int NROW = 1 << ROW_W;
    localparam int NV   = 7;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               vld_in = 1'b0;
    logic               rdy_in;
    coord_3d_t          v0 = '0, v1 = '0, v2 = '0;
    logic [COLOR_W-1:0] color = '0;
    logic               vld_out;
    logic               rdy_out = 1'b0;
    coord_3d_t          tv0, tv1, tv2;
    metadata_t          tmeta;
    logic [15:0]        tile_cnt;

    tile_dispatch #(.TILE_W_LOG2(TW), .TILE_H_LOG2(TH)) dut (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in),
        .v0(v0), .v1(v1), .v2(v2), .color(color),
        .vld_out(vld_out), .rdy_out(rdy_out),
        .tv0(tv0), .tv1(tv1), .tv2(tv2), .tmeta(tmeta), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int                 tx;
        int                 ty;
        logic [COLOR_W-1:0] col;
        coord_3d_t          a, b, c;
    } job_t;

    typedef struct {
        int x0, y0, x1, y1, x2, y2;
        int frac;
        int col;
        int n;
        int jx[6];
        int jy[6];
    } vec_t;

    job_t      q[$];
    int        log_tx[$], log_ty[$];
    int        checks = 0, errors = 0;
    int        model_cnt = 0, since_acc = 2;
    bit        rand_rdy = 1'b0, last_acc = 1'b0, stalled = 1'b0;
    coord_3d_t s_tv0, s_tv1, s_tv2;
    metadata_t s_meta;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic int fdiv(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    // Expected job list: every tile overlapped by the clamped pixel bounding box, row-major
    task automatic add_jobs(input coord_3d_t a, input coord_3d_t b, input coord_3d_t c,
                            input logic [COLOR_W-1:0] col);
        int xs[3], ys[3];
        int mnx, mxx, mny, mxy, tx0, tx1, ty0, ty1;
        job_t j;
        xs[0] = fdiv($signed(a.x), 1 << FX_W); ys[0] = fdiv($signed(a.y), 1 << FX_W);
        xs[1] = fdiv($signed(b.x), 1 << FX_W); ys[1] = fdiv($signed(b.y), 1 << FX_W);
        xs[2] = fdiv($signed(c.x), 1 << FX_W); ys[2] = fdiv($signed(c.y), 1 << FX_W);
        mnx = xs[0]; mxx = xs[0]; mny = ys[0]; mxy = ys[0];
        for (int i = 1; i < 3; i++) begin
            if (xs[i] < mnx) mnx = xs[i];
            if (xs[i] > mxx) mxx = xs[i];
            if (ys[i] < mny) mny = ys[i];
            if (ys[i] > mxy) mxy = ys[i];
        end
        if (mxx < 0 || mxy < 0) return;
        tx0 = fdiv(mnx, 1 << TW); tx1 = fdiv(mxx, 1 << TW);
        ty0 = fdiv(mny, 1 << TH); ty1 = fdiv(mxy, 1 << TH);
        if (tx0 > NCOL - 1 || ty0 > NROW - 1) return;
        if (tx0 < 0) tx0 = 0;
        if (ty0 < 0) ty0 = 0;
        if (tx1 > NCOL - 1) tx1 = NCOL - 1;
        if (ty1 > NROW - 1) ty1 = NROW - 1;
        for (int ty = ty0; ty <= ty1; ty++)
            for (int tx = tx0; tx <= tx1; tx++) begin
                j = '{tx, ty, col, a, b, c};
                q.push_back(j);
            end
    endtask

    // One clock: check handshake-level outputs against the model, then advance the model
    task automatic tick();
        bit exp_rdy, exp_vld, acc, hs;
        coord_3d_t a, b, c;
        logic [COLOR_W-1:0] col;
        if (rand_rdy) rdy_out = ($urandom_range(0, 3) != 0);
        exp_rdy = rst_n && (q.size() == 0) && (since_acc >= 2);
        exp_vld = (q.size() != 0) && (since_acc >= 2);
        chk("rdy_in", 64'(rdy_in), 64'(exp_rdy));
        chk("vld_out", 64'(vld_out), 64'(exp_vld));
        acc = rst_n && vld_in && exp_rdy;
        hs  = rst_n && exp_vld && rdy_out;
        a = v0; b = v1; c = v2; col = color;
        if (hs) begin
            chk("job_tile_x", 64'(tmeta.tile_x), 64'(q[0].tx));
            chk("job_tile_y", 64'(tmeta.tile_y), 64'(q[0].ty));
            chk("job_color", 64'(tmeta.color), 64'(q[0].col));
            chk("job_tv0", 64'(tv0), 64'(q[0].a));
            chk("job_tv1", 64'(tv1), 64'(q[0].b));
            chk("job_tv2", 64'(tv2), 64'(q[0].c));
            log_tx.push_back(int'(tmeta.tile_x));
            log_ty.push_back(int'(tmeta.tile_y));
            void'(q.pop_front());
            if (model_cnt < 65535) model_cnt++;
        end
        stalled = rst_n && exp_vld && !rdy_out;
        if (stalled) begin
            s_tv0 = tv0; s_tv1 = tv1; s_tv2 = tv2; s_meta = tmeta;
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            since_acc = 2;
            model_cnt = 0;
            stalled   = 1'b0;
        end else if (acc) begin
            add_jobs(a, b, c, col);
            since_acc = 1;
        end else if (since_acc < 2) begin
            since_acc++;
        end
        last_acc = acc;
        chk("tile_cnt", 64'(tile_cnt), 64'(model_cnt));
        if (stalled) begin
            chk("stall_vld_out", 64'(vld_out), 64'(1));
            chk("stall_tv0", 64'(tv0), 64'(s_tv0));
            chk("stall_tv1", 64'(tv1), 64'(s_tv1));
            chk("stall_tv2", 64'(tv2), 64'(s_tv2));
            chk("stall_tmeta", 64'(tmeta), 64'(s_meta));
        end
    endtask

    task automatic send(input int x0, input int y0, input int x1, input int y1,
                        input int x2, input int y2, input int frac, input int col);
        v0 = '{x: COORD_W'(x0 * (1 << FX_W) + frac), y: COORD_W'(y0 * (1 << FX_W) + frac), z: COORD_W'(11)};
        v1 = '{x: COORD_W'(x1 * (1 << FX_W) + frac), y: COORD_W'(y1 * (1 << FX_W) + frac), z: COORD_W'(22)};
        v2 = '{x: COORD_W'(x2 * (1 << FX_W) + frac), y: COORD_W'(y2 * (1 << FX_W) + frac), z: COORD_W'(33)};
        color    = COLOR_W'(col);
        vld_in   = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 500 && !last_acc; i++) tick();
        if (!last_acc) fail("accept_timeout");
        vld_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && !(q.size() == 0 && since_acc >= 2); i++) tick();
        if (!(q.size() == 0 && since_acc >= 2)) fail("drain_timeout");
    endtask

    vec_t vec[NV];

    initial begin
        vec[0] = '{1, 14, 7, 2, 12, 15, 0, 1, 1, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}};
        vec[1] = '{1, 1, 20, 1, 1, 2, 9, 2, 2, '{0, 1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}};
        vec[2] = '{-5, 0, 40, 8, 10, 17, 0, 3, 6, '{0, 1, 2, 0, 1, 2}, '{0, 0, 0, 1, 1, 1}};
        vec[3] = '{-1, 3, -20, 5, -2, 40, 15, 4, 0, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}};
        vec[4] = '{10, 300, 20, 260, 30, 270, 5, 5, 0, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}};
        vec[5] = '{250, 250, 300, 255, 240, 280, 3, 6, 1, '{15, 0, 0, 0, 0, 0}, '{15, 0, 0, 0, 0, 0}};
        vec[6] = '{15, 15, 16, 16, 15, 16, 0, 7, 4, '{0, 1, 0, 1, 0, 0}, '{0, 0, 1, 1, 0, 0}};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy_in", 64'(rdy_in), 64'(0));
        chk("rst_vld_out", 64'(vld_out), 64'(0));
        chk("rst_tile_cnt", 64'(tile_cnt), 64'(0));
        chk("rst_tv0", 64'(tv0), 64'(0));
        chk("rst_tv1", 64'(tv1), 64'(0));
        chk("rst_tv2", 64'(tv2), 64'(0));
        chk("rst_tmeta", 64'(tmeta), 64'(0));
        rst_n = 1'b1;
        #1;

        // Directed vector table, raster always ready
        rdy_out = 1'b1;
        for (int i = 0; i < NV; i++) begin
            int cnt0;
            cnt0 = model_cnt;
            log_tx.delete();
            log_ty.delete();
            send(vec[i].x0, vec[i].y0, vec[i].x1, vec[i].y1, vec[i].x2, vec[i].y2, vec[i].frac, vec[i].col);
            drain();
            chk($sformatf("vec%0d_jobs", i), 64'(log_tx.size()), 64'(vec[i].n));
            for (int k = 0; k < vec[i].n && k < log_tx.size(); k++) begin
                chk($sformatf("vec%0d_job%0d_x", i, k), 64'(log_tx[k]), 64'(vec[i].jx[k]));
                chk($sformatf("vec%0d_job%0d_y", i, k), 64'(log_ty[k]), 64'(vec[i].jy[k]));
            end
            chk($sformatf("vec%0d_cnt", i), 64'(tile_cnt), 64'(cnt0 + vec[i].n));
            chk($sformatf("vec%0d_rdy_in", i), 64'(rdy_in), 64'(1));
        end

        // Raster stalls for three cycles on the second tile
        log_tx.delete();
        log_ty.delete();
        send(-5, 0, 40, 8, 10, 17, 0, 9);
        for (int i = 0; i < 20 && log_tx.size() < 1; i++) tick();
        if (log_tx.size() < 1) fail("stall_first_job");
        rdy_out = 1'b0;
        repeat (3) tick();
        chk("stall_no_advance", 64'(log_tx.size()), 64'(1));
        rdy_out = 1'b1;
        tick();
        chk("stall_resume_jobs", 64'(log_tx.size()), 64'(2));
        if (log_tx.size() == 2) begin
            chk("stall_resume_x", 64'(log_tx[1]), 64'(1));
            chk("stall_resume_y", 64'(log_ty[1]), 64'(0));
        end
        drain();
        chk("stall_total_jobs", 64'(log_tx.size()), 64'(6));

        // Reset pulse while the second job is being offered
        log_tx.delete();
        log_ty.delete();
        send(-5, 0, 40, 8, 10, 17, 0, 10);
        for (int i = 0; i < 20 && log_tx.size() < 1; i++) tick();
        if (log_tx.size() < 1) fail("midrst_first_job");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_vld_out", 64'(vld_out), 64'(0));
        chk("midrst_tile_cnt", 64'(tile_cnt), 64'(0));
        chk("midrst_rdy_in", 64'(rdy_in), 64'(1));
        repeat (8) tick();
        chk("midrst_no_more_jobs", 64'(log_tx.size()), 64'(1));

        // Random triangles, random raster back-pressure, vld_in toggling while busy
        rand_rdy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int cx, cy;
            cx = int'($urandom_range(0, 360)) - 60;
            cy = int'($urandom_range(0, 360)) - 60;
            vld_in = ($urandom_range(0, 1) == 1);
            v0 = '{x: COORD_W'((cx + int'($urandom_range(0, 80)) - 40) * (1 << FX_W) + int'($urandom_range(0, 15))),
                   y: COORD_W'((cy + int'($urandom_range(0, 80)) - 40) * (1 << FX_W) + int'($urandom_range(0, 15))),
                   z: COORD_W'($urandom)};
            v1 = '{x: COORD_W'((cx + int'($urandom_range(0, 80)) - 40) * (1 << FX_W) + int'($urandom_range(0, 15))),
                   y: COORD_W'((cy + int'($urandom_range(0, 80)) - 40) * (1 << FX_W) + int'($urandom_range(0, 15))),
                   z: COORD_W'($urandom)};
            v2 = '{x: COORD_W'((cx + int'($urandom_range(0, 80)) - 40) * (1 << FX_W) + int'($urandom_range(0, 15))),
                   y: COORD_W'((cy + int'($urandom_range(0, 80)) - 40) * (1 << FX_W) + int'($urandom_range(0, 15))),
                   z: COORD_W'($urandom)};
            color = COLOR_W'($urandom);
            tick();
        end
        vld_in = 1'b0;
        drain();
        rand_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_dispatch.md
TILE_DISPATCH -- requirements
Module: tile_dispatch

Interface
REQ-001 SHALL have parameter: TILE_W_LOG2, 4, log2 of tile width in pixels.
REQ-002 SHALL have parameter: TILE_H_LOG2, 4, log2 of tile height in pixels.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port: rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port: vld_in  in  1  upstream triangle valid.
REQ-006 SHALL have port: rdy_in  out  1  block accepts a triangle.
REQ-007 SHALL have ports: v0, v1, v2  in  coord_3d_t  vertices, fixed point with `FX_FRAC_BITS fraction.
REQ-008 SHALL have port: color  in  `COLOR_BITS  triangle color.
REQ-009 SHALL have port: vld_out  out  1  tile job valid to raster.
REQ-010 SHALL have port: rdy_out  in  1  raster ready.
REQ-011 SHALL have ports: tv0, tv1, tv2  out  coord_3d_t  latched vertices, unmodified.
REQ-012 SHALL have port: tmeta  out  metadata_t  color plus current tile_x, tile_y.
REQ-013 SHALL have port: tile_cnt  out  16  total tile jobs issued, saturating.

Function
REQ-014 SHALL use FSM states IDLE, BBOX, ISSUE.
REQ-015 SHALL drive rdy_in = rst_n && (state==IDLE); the handshake is vld_in&&rdy_in at posedge.
REQ-016 SHALL, on accept, latch v0..v2 and color and go IDLE->BBOX.
REQ-017 SHALL, in BBOX (exactly one cycle), compute pixel = coord >>> `FX_FRAC_BITS (arithmetic) and per-axis min/max over the three vertices.
REQ-018 SHALL compute tile index = pixel >>> TILE_W_LOG2 (x) or TILE_H_LOG2 (y), clamped to [0, 2**`TILE_COLUMNS_BITS-1] (x) and [0, 2**`TILE_ROWS_BITS-1] (y).
REQ-019 SHALL cull the triangle when max_x<0, max_y<0, min tile x > last column, or min tile y > last row: BBOX->IDLE, no job issued.
REQ-020 SHALL otherwise go BBOX->ISSUE with tile_x=min_tx, tile_y=min_ty.
REQ-021 SHALL assert vld_out only in ISSUE; first vld_out is 2 cycles after the accept edge.
REQ-022 SHALL hold tv*, tmeta and vld_out stable while vld_out && !rdy_out.
REQ-023 SHALL, on vld_out&&rdy_out, step row-major: tile_x+1 until max_tx, then tile_x=min_tx and tile_y+1 until max_ty.
REQ-024 SHALL, on handshake of tile (max_tx, max_ty), go ISSUE->IDLE with vld_out low the next cycle; no bubble between tiles of one triangle.
REQ-025 SHALL increment tile_cnt on each vld_out&&rdy_out and hold at 16'hFFFF.
REQ-026 SHALL ignore vld_in outside IDLE; tmeta.color SHALL equal the latched color for every job.

Reset
REQ-027 SHALL, while rst_n low at posedge, set state=IDLE, vld_out=0, tile_cnt=0, tv*/tmeta=0; rdy_in=0 while rst_n low.
REQ-028 SHALL abandon any in-flight triangle on reset mid-ISSUE and issue no further jobs for it.

Verification
REQ-029 SHALL cover: triangle (1,14),(7,2),(12,15) color 1, rdy_out=1 -> exactly one job tile (0,0), vld_out 2 cycles after accept, tile_cnt=1.
REQ-030 SHALL cover: triangle (1,1),(20,1),(1,2) -> jobs (0,0) then (1,0) on consecutive cycles, then IDLE, rdy_in=1.
REQ-031 SHALL cover: triangle x in [-5,40], y in [0,17] -> clamp; jobs (0,0),(1,0),(2,0),(0,1),(1,1),(2,1) in order (TILE_COLUMNS_BITS>=2, TILE_ROWS_BITS>=2).
REQ-032 SHALL cover: rdy_out low 3 cycles during ISSUE -> vld_out high and tv*, tmeta unchanged; advances one tile on the first ready cycle.
REQ-033 SHALL cover: all vertices x<0 -> no vld_out, rdy_in high 2 cycles after accept, tile_cnt unchanged.
REQ-034 SHALL cover: rst_n low 1 cycle during the second job of REQ-031 -> vld_out=0, tile_cnt=0, rdy_in=1 after release, no further jobs.
